// File: rtl/sine_pkg.sv
// Shared types and constants for the sine sample sequencer.
// Holds FSM encodings, quadrant codes and default widths.
package sine_pkg;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_t;

  // Quadrant = top two phase bits.
  localparam logic [1:0] Q_RISE  = 2'd0;
  localparam logic [1:0] Q_FALL  = 2'd1;
  localparam logic [1:0] Q_NRISE = 2'd2;
  localparam logic [1:0] Q_NFALL = 2'd3;

endpackage

// File: rtl/sine_seq_ctrl.sv
// Phase-accumulator sequencer turning a quarter-wave LUT into a signed
// full-period sample stream.
// Ports: clk, rst (sync, active-high); start/stop pulses; cfg_inc,
// cfg_phase0, cfg_len run config; lut_addr/lut_data to the external LUT;
// out_data/out_valid/out_ready sample handshake; busy, done status.
module sine_seq_ctrl
  import sine_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic [PHASE_W-1:0] cfg_phase0,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [DATA_W-1:0]  lut_data,
  output logic [DATA_W:0]    out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  state_t state, state_nx;

  logic [PHASE_W-1:0] phase, phase_nx;
  logic [PHASE_W-1:0] inc, inc_nx;
  logic [LEN_W-1:0]   len, len_nx;
  logic [LEN_W-1:0]   count, count_nx;
  logic [DATA_W:0]    out_data_nx;
  logic               out_valid_nx;
  logic               done_nx;

  logic [1:0]        q;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W:0]   mag;
  logic [DATA_W:0]   sample;
  logic              issue;
  logic              accept;

  assign q   = phase[PHASE_W-1 -: 2];
  assign idx = phase[PHASE_W-3 -: ADDR_W];

  // Falling quadrants read the quarter-wave table backwards.
  always_comb begin
    lut_addr = idx;
    unique case (q)
      Q_RISE:  lut_addr = idx;
      Q_FALL:  lut_addr = ~idx;
      Q_NRISE: lut_addr = idx;
      Q_NFALL: lut_addr = ~idx;
      default: lut_addr = idx;
    endcase
  end

  // Zero-extended magnitude keeps the negation in range.
  assign mag    = {1'b0, lut_data};
  assign sample = q[1] ? -mag : mag;

  assign issue  = !out_valid || out_ready;
  assign accept = out_valid && out_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      inc       <= '0;
      len       <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      phase     <= phase_nx;
      inc       <= inc_nx;
      len       <= len_nx;
      count     <= count_nx;
      out_data  <= out_data_nx;
      out_valid <= out_valid_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    phase_nx     = phase;
    inc_nx       = inc;
    len_nx       = len;
    count_nx     = count;
    out_data_nx  = out_data;
    out_valid_nx = out_valid;
    done_nx      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          phase_nx = cfg_phase0;
          inc_nx   = cfg_inc;
          len_nx   = cfg_len;
          count_nx = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          // A pending unaccepted sample is still drained via LAST.
          if (out_valid && !out_ready) begin
            state_nx = LAST;
          end else begin
            out_valid_nx = 1'b0;
            done_nx      = 1'b1;
            state_nx     = IDLE;
          end
        end else if (issue) begin
          out_data_nx  = sample;
          out_valid_nx = 1'b1;
          phase_nx     = phase + inc;
          count_nx     = count + LEN_W'(1);
          // len == 0 runs until stop; count may wrap freely then.
          if (len != '0 && count_nx == len) begin
            state_nx = LAST;
          end
        end
      end
      LAST: begin
        if (accept) begin
          out_valid_nx = 1'b0;
          done_nx      = 1'b1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Self-checking bench for sine_seq_ctrl with a behavioural LUT.
// Expected samples are queued at start and popped on each accept.
module tb_sine_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] cfg_inc;
  logic [15:0] cfg_phase0;
  logic [15:0] cfg_len;
  logic [4:0]  lut_addr;
  logic [7:0]  lut_data;
  logic [8:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  logic [8:0] exp_q [$];

  sine_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cfg_inc    (cfg_inc),
    .cfg_phase0 (cfg_phase0),
    .cfg_len    (cfg_len),
    .lut_addr   (lut_addr),
    .lut_data   (lut_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  // Injective stand-in LUT: L(a) = a*8 + 7.
  assign lut_data = {lut_addr, 3'b111};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] lval(input logic [4:0] a);
    return {1'b0, a, 3'b111};
  endfunction

  function automatic logic [8:0] model(input logic [15:0] ph);
    logic [1:0] q;
    logic [4:0] idx;
    logic [4:0] a;
    q   = ph[15:14];
    idx = ph[13:9];
    a   = q[0] ? (5'd31 - idx) : idx;
    return q[1] ? (9'd0 - lval(a)) : lval(a);
  endfunction

  task automatic cycle(input bit rdy, input bit st, input bit sp,
                       output bit acc, output logic [8:0] d,
                       output bit v, output bit dn);
    @(negedge clk);
    out_ready = rdy;
    start     = st;
    stop      = sp;
    v   = out_valid;
    acc = out_valid && rdy;
    d   = out_data;
    dn  = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 9'd0 || busy !== 1'b0 ||
        done !== 1'b0 || lut_addr !== 5'd0) begin
      failures++;
      $display("FAIL reset: v=%b d=%h busy=%b done=%b addr=%0d want 0",
               out_valid, out_data, busy, done, lut_addr);
    end
  endtask

  task automatic test_full_period(input bit bp);
    bit acc, v, dn, fin, pv, pr, rdy;
    logic [8:0] d, pd, e;
    int beats;
    logic [4:0] a;
    exp_q.delete();
    for (int k = 0; k < 128; k++) begin
      a = ((k / 32) % 2 == 1) ? 5'(31 - (k % 32)) : 5'(k % 32);
      exp_q.push_back(k < 64 ? lval(a) : 9'd0 - lval(a));
    end
    cfg_phase0 = 16'h0000;
    cfg_inc    = 16'h0200;
    cfg_len    = 16'd128;
    cycle(1'b1, 1'b1, 1'b0, acc, d, v, dn);
    pv = 1'b0; pr = 1'b1; pd = '0; beats = 0; fin = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      rdy = bp ? c[0] : 1'b1;
      cycle(rdy, 1'b0, 1'b0, acc, d, v, dn);
      if (pv && !pr) begin
        checks++;
        if (!v || d !== pd) begin
          failures++;
          $display("FAIL stall_hold: v=%b d=%h want v=1 d=%h", v, d, pd);
        end
      end
      if (acc) begin
        beats++;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        if (d !== e) begin
          failures++;
          $display("FAIL period_sample %0d: got %h want %h", beats, d, e);
        end
      end
      if (dn) begin
        fin = 1'b1;
        checks++;
        if (beats != 128 || busy !== 1'b0) begin
          failures++;
          $display("FAIL period_done: beats=%0d busy=%b want 128,0",
                   beats, busy);
        end
      end
      pv = v; pr = rdy; pd = d;
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL period_timeout: beats=%0d want done", beats);
    end
    cycle(1'b1, 1'b0, 1'b0, acc, d, v, dn);
    checks++;
    if (dn !== 1'b0 || v !== 1'b0) begin
      failures++;
      $display("FAIL period_after: done=%b v=%b want 0,0", dn, v);
    end
  endtask

  task automatic test_wrap_stop;
    bit acc, v, dn, fin, sp;
    logic [8:0] d, e;
    int beats;
    exp_q.delete();
    for (int k = 0; k < 5; k++)
      exp_q.push_back(model(16'hFE00 + 16'(k * 512)));
    cfg_phase0 = 16'hFE00;
    cfg_inc    = 16'h0200;
    cfg_len    = 16'd0;
    cycle(1'b1, 1'b1, 1'b0, acc, d, v, dn);
    beats = 0; fin = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      sp = (beats == 4);
      cycle(1'b1, 1'b0, sp, acc, d, v, dn);
      if (acc) begin
        beats++;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        if (d !== e) begin
          failures++;
          $display("FAIL wrap_sample %0d: got %h want %h", beats, d, e);
        end
        if (beats == 1) begin
          checks++;
          if (d !== 9'h1F9) begin
            failures++;
            $display("FAIL wrap_first: got %h want 1f9", d);
          end
        end
        if (beats == 2) begin
          checks++;
          if (d !== 9'h007) begin
            failures++;
            $display("FAIL wrap_second: got %h want 007", d);
          end
        end
        if (sp) fin = 1'b1;
      end
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL wrap_timeout: beats=%0d want 5", beats);
    end
    cycle(1'b1, 1'b0, 1'b0, acc, d, v, dn);
    checks++;
    if (dn !== 1'b1 || busy !== 1'b0 || v !== 1'b0) begin
      failures++;
      $display("FAIL stop_done: done=%b busy=%b v=%b want 1,0,0",
               dn, busy, v);
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, 1'b0, 1'b0, acc, d, v, dn);
      checks++;
      if (v !== 1'b0 || dn !== 1'b0) begin
        failures++;
        $display("FAIL stop_quiet: v=%b done=%b want 0,0", v, dn);
      end
    end
  endtask

  task automatic test_start_ignored;
    bit acc, v, dn, fin, st, sent;
    logic [8:0] d, e;
    int beats;
    exp_q.delete();
    for (int k = 0; k < 16; k++)
      exp_q.push_back(model(16'(k * 512)));
    cfg_phase0 = 16'h0000;
    cfg_inc    = 16'h0200;
    cfg_len    = 16'd16;
    cycle(1'b1, 1'b1, 1'b0, acc, d, v, dn);
    beats = 0; fin = 1'b0; sent = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      st = (beats == 3 && !sent);
      if (st) begin
        sent       = 1'b1;
        cfg_inc    = 16'h0400;
        cfg_phase0 = 16'h1234;
        cfg_len    = 16'd4;
      end
      cycle(1'b1, st, 1'b0, acc, d, v, dn);
      if (acc) begin
        beats++;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
        if (d !== e) begin
          failures++;
          $display("FAIL busy_start %0d: got %h want %h", beats, d, e);
        end
      end
      if (dn) begin
        fin = 1'b1;
        checks++;
        if (beats != 16 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL busy_start_done: beats=%0d want 16", beats);
        end
      end
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL busy_start_timeout: beats=%0d want done", beats);
    end
  endtask

  task automatic test_reset_mid;
    bit acc, v, dn;
    logic [8:0] d, e;
    int beats;
    exp_q.delete();
    for (int k = 0; k < 40; k++)
      exp_q.push_back(model(16'(k * 512)));
    cfg_phase0 = 16'h0000;
    cfg_inc    = 16'h0200;
    cfg_len    = 16'd0;
    cycle(1'b1, 1'b1, 1'b0, acc, d, v, dn);
    beats = 0;
    for (int c = 0; c < 100 && beats < 40; c++) begin
      cycle(1'b1, 1'b0, 1'b0, acc, d, v, dn);
      if (acc) begin
        beats++;
        checks++;
        e = exp_q.pop_front();
        if (d !== e) begin
          failures++;
          $display("FAIL mid_sample %0d: got %h want %h", beats, d, e);
        end
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || beats != 40) begin
      failures++;
      $display("FAIL mid_pre: v=%b beats=%0d want 1,40", out_valid, beats);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 9'd0 || busy !== 1'b0 ||
        done !== 1'b0 || lut_addr !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset: v=%b d=%h busy=%b done=%b addr=%0d want 0",
               out_valid, out_data, busy, done, lut_addr);
    end
  endtask

  task automatic test_edge_cfg;
    bit acc, v, dn, fin;
    logic [8:0] d, e;
    int beats, want;
    for (int t = 0; t < 2; t++) begin
      exp_q.delete();
      cfg_inc = 16'h0000;
      if (t == 0) begin
        cfg_phase0 = 16'h0000;
        cfg_len    = 16'd1;
        want       = 1;
        exp_q.push_back(9'h007);
      end else begin
        cfg_phase0 = 16'h4000;
        cfg_len    = 16'd4;
        want       = 4;
        repeat (4) exp_q.push_back(9'h0FF);
      end
      cycle(1'b1, 1'b1, 1'b0, acc, d, v, dn);
      beats = 0; fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
        cycle(1'b1, 1'b0, 1'b0, acc, d, v, dn);
        if (acc) begin
          beats++;
          checks++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
          if (d !== e) begin
            failures++;
            $display("FAIL edge%0d_sample %0d: got %h want %h",
                     t, beats, d, e);
          end
        end
        if (dn) begin
          fin = 1'b1;
          checks++;
          if (beats != want || busy !== 1'b0) begin
            failures++;
            $display("FAIL edge%0d_done: beats=%0d busy=%b want %0d,0",
                     t, beats, busy, want);
          end
        end
      end
      checks++;
      if (!fin) begin
        failures++;
        $display("FAIL edge%0d_timeout: beats=%0d", t, beats);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    out_ready  = 1'b1;
    cfg_inc    = '0;
    cfg_phase0 = '0;
    cfg_len    = '0;
    test_reset();
    test_full_period(1'b0);
    test_full_period(1'b1);
    test_wrap_stop();
    test_start_ignored();
    test_reset_mid();
    test_edge_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
